regbank_rr_writer: RTL and testbench
====================================

Name: regbank_rr_writer

Overview:
- Shares one bank of NREGS registers between NREQ independent write requesters.
- Arbitration is round-robin, and at most one write is committed per clock.
- The register storage is built from the team's existing register_bank cell, one instance per register, each driven by a decoded per-register wr_en.
- A single asynchronous-index read port exposes bank contents to downstream logic.

Parameters:
- WIDTH, 8, data width of each register.
- NREQ, 4, number of write requesters (2..8).
- NREGS, 4, number of registers in the bank (power of two, >=2).
- AW, 2, register address width, equal to log2(NREGS).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester write request; held high until granted.
- req_addr  in  NREQ*AW  packed target addresses, requester i at bits [i*AW +: AW].
- req_data  in  NREQ*WIDTH  packed write data, requester i at bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, combinational in the request cycle.
- rd_addr  in  AW  read index.
- rd_data  out  WIDTH  contents of register rd_addr.
- last_id  out  log2(NREQ)  index of most recent winner, registered.
- wr_cnt  out  16  count of committed writes, registered, wraps.

Behaviour:
- Reset, when rst==0 at a rising edge:
  - all registers, last_id and wr_cnt go to 0;
  - the round-robin pointer ptr goes to 0;
  - gnt is forced to 0 while rst==0, so no write commits in a reset cycle.
- Arbitration, purely combinational from req and ptr:
  - search starts at index ptr and moves upward with wrap-around;
  - the first asserted req wins, and gnt has exactly that bit set;
  - if req==0, gnt==0.
- Commit:
  - at the edge ending a cycle with gnt[k]==1, register req_addr[k] loads req_data[k];
  - all other registers hold.
  - In the same edge: ptr <= (k+1) mod NREQ, last_id <= k, wr_cnt <= wr_cnt+1.
- Idle cycle: ptr, last_id and wr_cnt all hold.
- Handshake:
  - a requester sees gnt in the request cycle and may drop or change req next cycle;
  - an ungranted requester must hold req, addr and data stable.
- Latency:
  - grant has zero cycles of latency;
  - written data is visible on rd_data one cycle after the grant cycle.
- Read:
  - rd_data is a combinational mux of the register outputs;
  - read-during-write to the same address returns the old value in the grant cycle and the new value after the edge.
- Fairness: with all NREQ requesters continuously asserted, each is granted exactly once every NREQ cycles.
- Collisions: requesters targeting the same address are serialised by arbitration; the last committed write wins. No error is flagged.
- wr_cnt wraps from 0xFFFF to 0x0000.
- Reset mid-operation: pending requests are dropped from arbitration (gnt stays 0) until rst returns high. Arbitration then restarts from ptr=0.
- Out-of-range indices cannot occur: NREGS==2^AW by construction.

Decomposition:
- Shared package regbank_pkg holds:
  - the default WIDTH/NREQ/NREGS constants;
  - an IDW = log2(NREQ) helper function;
  - the wr_cnt width constant, 16.
- Sub-module rr_pick: combinational round-robin picker, (req, ptr) -> one-hot gnt plus encoded winner index.
- Storage uses NREGS instances of register_bank, with:
  - wr_en = any_gnt & (winner_addr == j);
  - in = winner_data.
  - Because register_bank's own reset is synchronous active-low, the top-level rst connects straight through.

Test Plan:
- Reset clears state: write 0xAA to reg 1, then assert rst=0 for 2 cycles. Expect rd_data=0 at every rd_addr, wr_cnt=0, last_id=0, and gnt=0 even with req=4'b1111.
- Single requester: req=4'b0100, addr=3, data=0x5C. Expect gnt=4'b0100 in the same cycle; next cycle rd_addr=3 gives 0x5C, last_id=2, wr_cnt=1.
- Full contention: req=4'b1111 held for 8 cycles with distinct addresses. Expect the gnt sequence 0001, 0010, 0100, 1000, 0001, ... and wr_cnt=8.
- Pointer wrap: after the winner is 3, req=4'b1001. Expect gnt=4'b0001 and then, with req=4'b1000, gnt=4'b1000.
- Same-address collision: req0 writes 0x11 and req1 writes 0x22, both to reg 0, with req held until granted. Expect two grants (req0 first from ptr=0); final rd_data at reg 0 is 0x22.
- Read-during-write: rd_addr=2 holds 0x33 while reg 2 is written with 0x44. Expect rd_data=0x33 in the grant cycle and 0x44 the next cycle.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the round-robin register-bank writer.
package regbank_pkg;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefNreq  = 4;
   localparam int unsigned DefNregs = 4;
   localparam int unsigned CntW     = 16;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned idw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regbank_rr_writer_if.sv
// Request/grant and read-port bundle between requesters and the shared register bank.
interface regbank_rr_writer_if
   import regbank_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned NREQ  = DefNreq,
   parameter int unsigned AW    = 2,
   parameter int unsigned IDW   = 2
);

   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       gnt;
   logic [AW-1:0]         rd_addr;
   logic [WIDTH-1:0]      rd_data;
   logic [IDW-1:0]        last_id;
   logic [CntW-1:0]       wr_cnt;

   modport master (
      output req, req_addr, req_data, rd_addr,
      input  gnt, rd_data, last_id, wr_cnt
   );

   modport slave (
      input  req, req_addr, req_data, rd_addr,
      output gnt, rd_data, last_id, wr_cnt
   );

endinterface

// File: rtl/register_bank.sv
// Single storage register with synchronous active-low reset and write enable.
module register_bank #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] out_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q <= '0;
      end else if (wr_en_i) begin
         data_q <= in_i;
      end
   end

   assign out_o = data_q;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, else wrap to lowest.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [NREQ-1:0] upper;

   always_comb begin
      upper = '0;
      idx_o = '0;
      any_o = |req_i;
      gnt_o = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         upper[i] = req_i[i] && (IDW'(i) >= ptr_i);
      end
      // Descending scan so the lowest set bit is the last one assigned.
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (|upper) begin
            if (upper[i]) idx_o = IDW'(i);
         end else if (req_i[i]) begin
            idx_o = IDW'(i);
         end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
         gnt_o[i] = any_o && (IDW'(i) == idx_o);
      end
   end

endmodule

// File: rtl/regbank_rr_writer.sv
// Register bank shared by NREQ writers; round-robin arbitration, one commit per clock.
module regbank_rr_writer
   import regbank_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned NREQ  = DefNreq,
   parameter int unsigned NREGS = DefNregs,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   regbank_rr_writer_if.slave  bus_io
);

   localparam int unsigned IDW = idw(NREQ);

   logic [NREQ-1:0]  req_masked;
   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   win_idx;
   logic             any_gnt;
   logic [AW-1:0]    win_addr;
   logic [WIDTH-1:0] win_data;
   logic [WIDTH-1:0] reg_out [NREGS];

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   last_id_q, last_id_d;
   logic [CntW-1:0]  wr_cnt_q, wr_cnt_d;

   // Requests are invisible during reset so nothing commits in a reset cycle.
   assign req_masked = bus_io.req & {NREQ{rst}};

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_i (req_masked),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (win_idx),
      .any_o (any_gnt)
   );

   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (win_idx == IDW'(i)) begin
            win_addr = bus_io.req_addr[i*AW +: AW];
            win_data = bus_io.req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      last_id_d = last_id_q;
      wr_cnt_d  = wr_cnt_q;
      if (any_gnt) begin
         ptr_d     = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
         last_id_d = win_idx;
         wr_cnt_d  = wr_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q     <= '0;
         last_id_q <= '0;
         wr_cnt_q  <= '0;
      end else begin
         ptr_q     <= ptr_d;
         last_id_q <= last_id_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   for (genvar j = 0; j < NREGS; j++) begin : g_reg
      register_bank #(
         .WIDTH (WIDTH)
      ) u_reg (
         .clk     (clk),
         .rst     (rst),
         .wr_en_i (any_gnt && (win_addr == AW'(j))),
         .in_i    (win_data),
         .out_o   (reg_out[j])
      );
   end

   assign bus_io.gnt     = gnt;
   assign bus_io.rd_data = reg_out[bus_io.rd_addr];
   assign bus_io.last_id = last_id_q;
   assign bus_io.wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_regbank_rr_writer.sv
// Directed vector bench for regbank_rr_writer with hand-computed expectations.
module tb_regbank_rr_writer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   regbank_rr_writer_if #(
      .WIDTH (8),
      .NREQ  (4),
      .AW    (2),
      .IDW   (2)
   ) bus ();

   regbank_rr_writer #(
      .WIDTH (8),
      .NREQ  (4),
      .NREGS (4),
      .AW    (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [1:0]  rd_addr;
      logic [3:0]  gnt;
      logic [7:0]  rd;
      logic [1:0]  last;
      logic [15:0] cnt;
   } vec_t;

   vec_t tab_a [3];
   vec_t tab_b [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Entered just after a rising edge; leaves just after the next one.
   task automatic apply_vec(input string tag, input vec_t v);
      bus.req      = v.req;
      bus.req_addr = v.addr;
      bus.req_data = v.data;
      bus.rd_addr  = v.rd_addr;
      #3;
      check({tag, " gnt"}, 32'(bus.gnt), 32'(v.gnt));
      check({tag, " rd_data"}, 32'(bus.rd_data), 32'(v.rd));
      @(posedge clk); #1;
      check({tag, " last_id"}, 32'(bus.last_id), 32'(v.last));
      check({tag, " wr_cnt"}, 32'(bus.wr_cnt), 32'(v.cnt));
   endtask

   function automatic vec_t mk(input logic [3:0] req, input logic [7:0] addr,
                               input logic [31:0] data, input logic [1:0] rd_addr,
                               input logic [3:0] gnt, input logic [7:0] rd,
                               input logic [1:0] last, input logic [15:0] cnt);
      vec_t v;
      v.req = req; v.addr = addr; v.data = data; v.rd_addr = rd_addr;
      v.gnt = gnt; v.rd = rd; v.last = last; v.cnt = cnt;
      return v;
   endfunction

   initial begin
      checks = 0;
      errors = 0;

      //            req      addr{3,2,1,0}            data{3,2,1,0}        rd  gnt      rd     last cnt
      tab_a[0] = mk(4'b0000, 8'h00,                   32'h0,               0, 4'b0000, 8'h00, 0, 0);
      tab_a[1] = mk(4'b0010, {2'd0,2'd0,2'd1,2'd0},   32'h0000_AA00,       1, 4'b0010, 8'h00, 1, 1);
      tab_a[2] = mk(4'b0000, 8'h00,                   32'h0,               1, 4'b0000, 8'hAA, 1, 1);

      tab_b[0]  = mk(4'b0100, {2'd0,2'd3,2'd0,2'd0},  32'h005C_0000,       3, 4'b0100, 8'h00, 2, 1);
      tab_b[1]  = mk(4'b0000, 8'h00,                  32'h0,               3, 4'b0000, 8'h5C, 2, 1);
      tab_b[2]  = mk(4'b1000, {2'd2,2'd0,2'd0,2'd0},  32'h3300_0000,       2, 4'b1000, 8'h00, 3, 2);
      tab_b[3]  = mk(4'b1001, {2'd2,2'd0,2'd0,2'd1},  32'h4400_0001,       2, 4'b0001, 8'h33, 0, 3);
      tab_b[4]  = mk(4'b1000, {2'd2,2'd0,2'd0,2'd0},  32'h4400_0000,       2, 4'b1000, 8'h33, 3, 4);
      tab_b[5]  = mk(4'b0000, 8'h00,                  32'h0,               2, 4'b0000, 8'h44, 3, 4);
      tab_b[6]  = mk(4'b0011, 8'h00,                  32'h0000_2211,       0, 4'b0001, 8'h00, 0, 5);
      tab_b[7]  = mk(4'b0010, 8'h00,                  32'h0000_2200,       0, 4'b0010, 8'h11, 1, 6);
      tab_b[8]  = mk(4'b0000, 8'h00,                  32'h0,               0, 4'b0000, 8'h22, 1, 6);
      tab_b[9]  = mk(4'b0000, 8'h00,                  32'h0,               1, 4'b0000, 8'h01, 1, 6);
      tab_b[10] = mk(4'b0000, 8'h00,                  32'h0,               3, 4'b0000, 8'h5C, 1, 6);

      // Power-on reset with every requester asserted.
      rst = 1'b0;
      bus.req = 4'b1111;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.rd_addr = '0;
      @(posedge clk); #1;
      check("por gnt c0", 32'(bus.gnt), 32'h0);
      @(posedge clk); #1;
      check("por gnt c1", 32'(bus.gnt), 32'h0);
      check("por wr_cnt", 32'(bus.wr_cnt), 32'h0);
      rst = 1'b1;
      bus.req = '0;

      for (int i = 0; i < 3; i++) apply_vec($sformatf("tab_a[%0d]", i), tab_a[i]);

      // Mid-operation reset: reg1 holds 0xAA, counters nonzero, requests pending.
      rst = 1'b0;
      bus.req = 4'b1111;
      for (int c = 0; c < 2; c++) begin
         #3;
         check($sformatf("rst gnt c%0d", c), 32'(bus.gnt), 32'h0);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      bus.req = '0;
      check("rst wr_cnt", 32'(bus.wr_cnt), 32'h0);
      check("rst last_id", 32'(bus.last_id), 32'h0);
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         #1;
         check($sformatf("rst rd_data[%0d]", a), 32'(bus.rd_data), 32'h0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) apply_vec($sformatf("tab_b[%0d]", i), tab_b[i]);

      // Full contention after reset: ptr was 2, so a 0001 first grant proves it restarted at 0.
      rst = 1'b0;
      bus.req = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.req = 4'b1111;
      bus.req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
      bus.req_data = 32'hC3C2_C1C0;
      for (int c = 0; c < 8; c++) begin
         #3;
         check($sformatf("rr gnt c%0d", c), 32'(bus.gnt), 32'(4'b0001 << (c % 4)));
         @(posedge clk); #1;
         check($sformatf("rr wr_cnt c%0d", c), 32'(bus.wr_cnt), 32'(c + 1));
         check($sformatf("rr last_id c%0d", c), 32'(bus.last_id), 32'(c % 4));
      end
      bus.req = '0;
      for (int a = 0; a < 4; a++) begin
         bus.rd_addr = 2'(a);
         #1;
         check($sformatf("rr rd_data[%0d]", a), 32'(bus.rd_data), 32'(8'hC0 + a));
      end
      @(posedge clk); #1;
      check("rr idle wr_cnt", 32'(bus.wr_cnt), 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
